fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Write-side arbiter that shares the single write port of an async FIFO between NREQ packet sources, all in the write clock domain. Grants are round-robin and packet-atomic: once a source wins, it owns the port until its last beat is accepted. Each FIFO word carries the source ID and a last flag, so the read-domain consumer can demultiplex. Sits between the requesters and the FIFO's winc/wdata/wfull/awfull interface.

Parameters:
NREQ, 4, number of requesters (2..16)
DW, 8, payload width per requester
IDW, 2, source-ID width; must equal clog2(NREQ)
FW, DW+IDW+1, FIFO word width; derived, never overridden

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-source beat valid
req_last  in  NREQ  per-source end-of-packet marker, qualified by req_valid
req_data  in  NREQ*DW  per-source payload; source i occupies bits [i*DW +: DW]
req_ready  out  NREQ  per-source beat accepted (combinational)
winc  out  1  FIFO write enable
wdata  out  FW  FIFO word {id, last, data}
wfull  in  1  FIFO full
awfull  in  1  FIFO almost full
grant_id  out  IDW  currently owning source (valid while busy)
busy  out  1  a packet is in progress

Behaviour:
- Clock wclk; reset wrst_n, asynchronous assert, active low. Reset values: state=IDLE, rr_ptr=NREQ-1, grant_id=0, busy=0, beat_cnt=0. Combinational outputs (winc, req_ready) evaluate to 0 while in reset.
- State machine has two states, IDLE and BURST.
- IDLE:
  - Arbitration runs only when at least one req_valid is high and wfull=0 and awfull=0.
  - Winner is the first asserted req_valid searching from rr_ptr+1 upward, modulo NREQ.
  - Winner is registered into grant_id and the state moves to BURST next cycle: one-cycle arbitration latency.
  - No beat is accepted in IDLE: req_ready=0, winc=0.
- BURST (busy=1):
  - req_ready[grant_id] = req_valid[grant_id] & ~wfull; all other req_ready bits are 0.
  - winc equals the granted source's req_ready.
  - wdata = {grant_id, req_last[grant_id], req_data[grant_id]} with zero added latency. wdata is don't-care when winc=0, but the bench expects it held at 0.
  - awfull is ignored inside BURST; the packet is never split.
  - On an accepted beat with last=1: rr_ptr <= grant_id, state <= IDLE. The next arbitration therefore happens in the following cycle (minimum one idle cycle between packets).
  - A granted source deasserting valid mid-packet stalls the port; no timeout, and the grant is held.
- beat_cnt counts accepted beats in the packet (8 bits, saturating at 255) and clears on return to IDLE. It is internal, for assertions only.
- Simultaneous events:
  - wfull rising during a beat: that beat is not accepted (ready=0), the source holds, and it retries when wfull falls.
  - A single-beat packet (last on the first beat) returns to IDLE after one transfer.
- Reset mid-packet: the FSM returns to IDLE immediately. The partial packet already in the FIFO is not retracted; the consumer resynchronises on the ID change.
- A source must hold valid/data/last stable until ready; this is checked by an assertion, not corrected by the block.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state enum {IDLE, BURST}
  - the FW field offset constants (ID_LSB = DW+1, LAST_BIT = DW)
  - a function to compute clog2 for the IDW check
- Sub-module rr_pick: a combinational round-robin priority picker taking (req[NREQ], ptr[IDW]) and returning (gnt_id[IDW], any). It is reusable elsewhere and unit-testable in isolation.

Test Plan:
- Reset, then source 2 sends a 3-beat packet (data 0xA1, 0xA2, 0xA3, last on the 3rd) -> grant in cycle 1, winc high on cycles 2–4, wdata = {2'd2, 0, 0xA1}, {2'd2, 0, 0xA2}, {2'd2, 1, 0xA3}; busy low on cycle 5.
- All 4 sources hold single-beat packets continuously from reset -> grant order 0, 1, 2, 3, 0, with one beat every 2 cycles.
- Source 1 mid-packet, source 0 requesting -> source 0 receives no ready until source 1's last beat is accepted; next grant goes to 2 if valid, else 3, else 0.
- wfull forced high on the 2nd beat of a 4-beat packet for 5 cycles -> winc=0 and req_ready=0 for those 5 cycles, the beat is retried with identical wdata, and no beat is lost or duplicated.
- awfull high in IDLE with source 3 valid -> no grant while awfull=1; grant to 3 one cycle after awfull falls. awfull rising mid-packet -> packet completes.
- wrst_n asserted asynchronously mid-packet (between clock edges) -> busy, winc and req_ready go to 0 immediately; after release, the next grant starts from source 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter.
// FIFO word layout is {id, last, data}; field offsets derive from the payload width.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int unsigned id_lsb(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned last_bit(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side signal bundle for fifo_wr_arbiter.
// master = the arbiter, slave = requesters plus FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned IDW  = 2
);
  localparam int unsigned FW = DW + IDW + 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               winc;
  logic [FW-1:0]      wdata;
  logic               wfull;
  logic               awfull;
  logic [IDW-1:0]     grant_id;
  logic               busy;

  modport master (
    input  req_valid, req_last, req_data, wfull, awfull,
    output req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_last, req_data, wfull, awfull,
    input  req_ready, winc, wdata, grant_id, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req searching from ptr+1 upward, modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  always_comb begin
    int unsigned idx;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!any && req[idx[IDW-1:0]]) begin
        any    = 1'b1;
        gnt_id = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one async-FIFO write port among NREQ sources.
// Each FIFO word is {source id, last, payload} so the read side can demultiplex.
import fifo_arb_pkg::*;

module fifo_wr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned IDW  = 2
) (
  input logic               wclk,
  input logic               wrst_n,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned FW       = DW + IDW + 1;
  localparam int unsigned ID_LSB   = id_lsb(DW);
  localparam int unsigned LAST_BIT = last_bit(DW);

  if (IDW != clog2(NREQ)) begin : g_bad_idw
    $error("fifo_wr_arbiter: IDW must equal clog2(NREQ)");
  end

  arb_state_e      state, state_nxt;
  logic [IDW-1:0]  grant_q;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  pick_id;
  logic            pick_any;
  logic [7:0]      beat_cnt;
  logic            g_valid;
  logic            g_last;
  logic [DW-1:0]   g_data;
  logic            accept;
  logic            start;
  logic [NREQ-1:0] ready;
  logic [FW-1:0]   wd;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  assign g_valid = bus.req_valid[grant_q];
  assign g_last  = bus.req_last[grant_q];
  assign g_data  = bus.req_data[grant_q*DW +: DW];

  // awfull gates only the start of a packet; an owned packet is never split
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    ready     = '0;
    wd        = '0;
    unique case (state)
      IDLE: begin
        if (pick_any && !bus.wfull && !bus.awfull) begin
          start     = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        accept         = g_valid & ~bus.wfull;
        ready[grant_q] = accept;
        if (accept) begin
          wd[ID_LSB +: IDW] = grant_q;
          wd[LAST_BIT]      = g_last;
          wd[DW-1:0]        = g_data;
          if (g_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rr_ptr   <= IDW'(NREQ - 1);
      grant_q  <= '0;
      beat_cnt <= '0;
    end else begin
      if (start) grant_q <= pick_id;
      if (accept && g_last) begin
        rr_ptr   <= grant_q;
        beat_cnt <= '0;
      end else if (accept && beat_cnt != 8'hFF) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.winc      = accept;
  assign bus.wdata     = wd;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state == BURST);

  a_hold: assert property (@(posedge wclk) disable iff (!wrst_n)
    (state == BURST && g_valid && !accept) |=> (g_valid && $stable(g_last) && $stable(g_data)));

  a_cnt_idle: assert property (@(posedge wclk) disable iff (!wrst_n)
    (state == IDLE) |-> (beat_cnt == 8'd0));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a per-cycle
// behavioural model of the arbitration rules, with per-source packet queues as stimulus.
module tb_fifo_wr_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned IDW  = 2;
  localparam int unsigned FW   = DW + IDW + 1;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW:0]   src_q [NREQ][$];
  bit            pending [NREQ];
  bit            rand_gate = 1'b0;
  bit            m_busy;
  int unsigned   m_owner;
  int unsigned   m_last;
  bit            m_acc;
  bit            m_acc_last;
  logic [FW-1:0] got_words [$];
  int unsigned   enq_beats;

  logic [FW-1:0] t1_exp [3] = '{11'h4A1, 11'h4A2, 11'h5A3};
  logic [FW-1:0] t4_exp [4] = '{11'h6D0, 11'h6D1, 11'h6D2, 11'h7D3};
  int unsigned   t2_ids [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int unsigned   t3_ids [7] = '{1, 1, 1, 1, 2, 3, 0};
  int unsigned   t6_ids [3] = '{0, 2, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int unsigned src, input int unsigned nbeats, input logic [DW-1:0] base);
    for (int unsigned b = 0; b < nbeats; b++)
      src_q[src].push_back({(b == nbeats - 1), base + DW'(b)});
    enq_beats += nbeats;
  endtask

  function automatic int unsigned beats_left();
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < NREQ; i++) s += src_q[i].size();
    return s;
  endfunction

  // A source offering a beat that was not taken keeps it up; otherwise it may idle randomly.
  task automatic drive_sources();
    for (int unsigned i = 0; i < NREQ; i++) begin
      logic v;
      v = 1'b0;
      if (src_q[i].size() != 0)
        v = pending[i] || !rand_gate || ($urandom_range(0, 3) != 0);
      bus.req_valid[i]            = v;
      bus.req_last[i]             = 1'b0;
      bus.req_data[i*DW +: DW]    = '0;
      if (v) begin
        bus.req_last[i]         = src_q[i][0][DW];
        bus.req_data[i*DW +: DW] = src_q[i][0][DW-1:0];
      end
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] er;
    logic [FW-1:0]   ew;
    er         = '0;
    ew         = '0;
    m_acc      = 1'b0;
    m_acc_last = 1'b0;
    if (m_busy && bus.req_valid[m_owner] && !bus.wfull) begin
      er[m_owner] = 1'b1;
      m_acc       = 1'b1;
      m_acc_last  = bus.req_last[m_owner];
      ew = FW'(m_owner * (2 ** (DW + 1)) + 32'(m_acc_last) * (2 ** DW)
               + 32'(bus.req_data[m_owner*DW +: DW]));
    end
    chk("busy", bus.busy, m_busy);
    if (m_busy) chk("grant_id", bus.grant_id, m_owner);
    chk("req_ready", bus.req_ready, er);
    chk("winc", bus.winc, m_acc);
    chk("wdata", bus.wdata, ew);
    if (bus.winc === 1'b1) got_words.push_back(bus.wdata);
  endtask

  task automatic model_advance();
    for (int unsigned i = 0; i < NREQ; i++)
      pending[i] = bus.req_valid[i] && !(m_acc && i == m_owner);
    if (!wrst_n) begin
      m_busy = 1'b0;
      m_last = NREQ - 1;
      for (int unsigned i = 0; i < NREQ; i++) pending[i] = 1'b0;
      return;
    end
    if (m_busy) begin
      if (m_acc) begin
        void'(src_q[m_owner].pop_front());
        if (m_acc_last) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end
    end else if (bus.req_valid != '0 && !bus.wfull && !bus.awfull) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        int unsigned c;
        c = (m_last + k) % NREQ;
        if (!m_busy && bus.req_valid[c]) begin
          m_owner = c;
          m_busy  = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge wclk);
    check_outputs();
    @(posedge wclk);
    model_advance();
    #1;
    drive_sources();
  endtask

  task automatic clear_sources();
    for (int unsigned i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      pending[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_last = NREQ - 1;
  endtask

  task automatic drain(input int unsigned limit);
    int unsigned n;
    n = 0;
    while ((m_busy || beats_left() != 0) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_left", beats_left(), 0);
  endtask

  task automatic chk_ids(input string tag, input int unsigned k, input int unsigned exp);
    if (k < got_words.size()) chk(tag, got_words[k][FW-1 -: IDW], exp);
    else chk(tag, 32'hFFFF_FFFF, exp);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.wfull     = 1'b0;
    bus.awfull    = 1'b0;
    m_owner       = 0;
    enq_beats     = 0;
    clear_sources();

    tick();
    tick();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_winc", bus.winc, 1'b0);

    // single 3-beat packet from source 2
    wrst_n = 1'b1;
    send(2, 3, 8'hA1);
    drive_sources();
    repeat (6) tick();
    chk("t1_count", got_words.size(), 3);
    for (int unsigned k = 0; k < 3; k++)
      if (k < got_words.size()) chk($sformatf("t1_word%0d", k), got_words[k], t1_exp[k]);
    chk("t1_busy_end", bus.busy, 1'b0);

    // all sources with single-beat packets pending from reset
    wrst_n = 1'b0;
    clear_sources();
    drive_sources();
    tick();
    for (int unsigned i = 0; i < NREQ; i++) begin
      send(i, 1, 8'h20 + 8'(i));
      send(i, 1, 8'h30 + 8'(i));
    end
    drive_sources();
    tick();
    wrst_n = 1'b1;
    got_words.delete();
    drain(200);
    chk("t2_count", got_words.size(), 8);
    for (int unsigned k = 0; k < 8; k++) chk_ids($sformatf("t2_id%0d", k), k, t2_ids[k]);

    // others wait for source 1's packet to finish
    got_words.delete();
    send(1, 4, 8'hB0);
    tick();
    tick();
    send(0, 1, 8'hC0);
    send(2, 1, 8'hC2);
    send(3, 1, 8'hC3);
    drain(100);
    chk("t3_count", got_words.size(), 7);
    for (int unsigned k = 0; k < 7; k++) chk_ids($sformatf("t3_id%0d", k), k, t3_ids[k]);

    // wfull stalls the 2nd beat for 5 cycles
    got_words.delete();
    send(3, 4, 8'hD0);
    begin
      int unsigned n;
      n = 0;
      while (got_words.size() < 1 && n < 20) begin
        tick();
        n++;
      end
    end
    bus.wfull = 1'b1;
    repeat (5) tick();
    chk("t4_words_in_full", got_words.size(), 1);
    bus.wfull = 1'b0;
    drain(50);
    chk("t4_count", got_words.size(), 4);
    for (int unsigned k = 0; k < 4; k++)
      if (k < got_words.size()) chk($sformatf("t4_word%0d", k), got_words[k], t4_exp[k]);

    // awfull blocks arbitration but not an owned packet
    got_words.delete();
    bus.awfull = 1'b1;
    send(3, 2, 8'hE0);
    drive_sources();
    repeat (4) tick();
    chk("t5_no_grant", bus.busy, 1'b0);
    bus.awfull = 1'b0;
    tick();
    chk("t5_grant", bus.busy, 1'b1);
    chk("t5_grant_id", bus.grant_id, 3);
    bus.awfull = 1'b1;
    drain(50);
    bus.awfull = 1'b0;
    chk("t5_count", got_words.size(), 2);

    // asynchronous reset mid-packet
    send(1, 4, 8'hF0);
    repeat (3) tick();
    chk("t6_busy_before", bus.busy, 1'b1);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("t6_rst_busy", bus.busy, 1'b0);
    chk("t6_rst_winc", bus.winc, 1'b0);
    chk("t6_rst_ready", bus.req_ready, 0);
    clear_sources();
    drive_sources();
    tick();
    tick();
    wrst_n = 1'b1;
    got_words.delete();
    send(2, 1, 8'h52);
    send(0, 1, 8'h50);
    send(3, 1, 8'h53);
    drive_sources();
    drain(50);
    for (int unsigned k = 0; k < 3; k++) chk_ids($sformatf("t6_id%0d", k), k, t6_ids[k]);

    // random traffic with random FIFO back-pressure and source idling
    got_words.delete();
    enq_beats = 0;
    rand_gate = 1'b1;
    repeat (600) begin
      for (int unsigned i = 0; i < NREQ; i++)
        if (src_q[i].size() == 0 && $urandom_range(0, 7) == 0)
          send(i, $urandom_range(1, 4), DW'($urandom));
      bus.wfull  = ($urandom_range(0, 9) == 0);
      bus.awfull = ($urandom_range(0, 7) == 0);
      tick();
    end
    bus.wfull  = 1'b0;
    bus.awfull = 1'b0;
    rand_gate  = 1'b0;
    drain(500);
    chk("rand_beats", got_words.size(), enq_beats);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
